// File: rtl/stmm_seq.sv
`default_nettype none
// ============================================================================
// Module      : stmm_seq
// Description : Command sequencer for a bank of StMM sub-units. For each
//               selected sub it loads an X vector from the activation buffer,
//               starts all selected subs together, waits for every completion,
//               then copies each Y vector back into the buffer.
// Revision    : 1.0  initial release
// ============================================================================
module stmm_seq #(
    parameter int SUB_NUM = 4,
    parameter int N       = 176,
    parameter int ADDR_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [SUB_NUM-1:0]  cmd_mask_i,
    input  logic [ADDR_W-1:0]   cmd_src_addr_i,
    input  logic [ADDR_W-1:0]   cmd_dst_addr_i,
    output logic [ADDR_W-1:0]   buf_raddr_o,
    input  logic [N*8-1:0]      buf_rdata_i,
    output logic                buf_we_o,
    output logic [ADDR_W-1:0]   buf_waddr_o,
    output logic [N*8-1:0]      buf_wdata_o,
    output logic [SUB_NUM-1:0]  input_we_o,
    output logic [N*8-1:0]      input_data_o,
    output logic [SUB_NUM-1:0]  exec_o,
    input  logic [SUB_NUM-1:0]  exec_done_i,
    output logic [SUB_NUM-1:0]  output_re_o,
    input  logic [N*8-1:0]      output_data_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int IDX_W = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_ADDR = 3'd1,
        S_LD_DATA = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT    = 3'd4,
        S_UL_RE   = 3'd5,
        S_UL_WR   = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t               state_q;
    logic [SUB_NUM-1:0]   mask_q;
    logic [ADDR_W-1:0]    src_q;
    logic [ADDR_W-1:0]    dst_q;
    logic [SUB_NUM-1:0]   pend_q;
    logic [IDX_W-1:0]     idx_q;

    logic [ADDR_W-1:0]    buf_raddr_q;
    logic                 buf_we_q;
    logic [ADDR_W-1:0]    buf_waddr_q;
    logic [SUB_NUM-1:0]   input_we_q;
    logic [SUB_NUM-1:0]   exec_q;
    logic [SUB_NUM-1:0]   output_re_q;
    logic                 busy_q;
    logic                 done_q;

    // {found, index} of the lowest set bit of m at or above position 'from'
    logic [IDX_W:0]       first_cmd;
    logic [IDX_W:0]       first_msk;
    logic [IDX_W:0]       next_sel;
    logic [SUB_NUM-1:0]   pend_d;

    function automatic logic [IDX_W:0] f_first(input logic [SUB_NUM-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int j = SUB_NUM - 1; j >= 0; j--) begin
            if (m[j] && (j >= from)) begin
                r = {1'b1, IDX_W'(j)};
            end
        end
        return r;
    endfunction

    function automatic logic [SUB_NUM-1:0] f_onehot(input logic [IDX_W-1:0] i);
        return SUB_NUM'(1) << i;
    endfunction

    // Sub selection search and sticky completion accumulation
    always_comb begin
        first_cmd = f_first(cmd_mask_i, 0);
        first_msk = f_first(mask_q, 0);
        next_sel  = f_first(mask_q, int'(idx_q) + 1);
        pend_d    = pend_q | (exec_done_i & mask_q);
    end

    // Sequencer FSM; every strobe is registered so it lands in its named state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            pend_q      <= '0;
            idx_q       <= '0;
            buf_raddr_q <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            input_we_q  <= '0;
            exec_q      <= '0;
            output_re_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            input_we_q  <= '0;
            exec_q      <= '0;
            output_re_q <= '0;
            buf_we_q    <= 1'b0;
            buf_raddr_q <= '0;
            buf_waddr_q <= '0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        mask_q <= cmd_mask_i;
                        src_q  <= cmd_src_addr_i;
                        dst_q  <= cmd_dst_addr_i;
                        pend_q <= '0;
                        busy_q <= 1'b1;
                        if (first_cmd[IDX_W]) begin
                            idx_q       <= first_cmd[IDX_W-1:0];
                            buf_raddr_q <= cmd_src_addr_i + ADDR_W'(first_cmd[IDX_W-1:0]);
                            state_q     <= S_LD_ADDR;
                        end else begin
                            // Empty mask: nothing to move, finish straight away
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_LD_ADDR: begin
                    input_we_q <= f_onehot(idx_q);
                    state_q    <= S_LD_DATA;
                end
                S_LD_DATA: begin
                    if (next_sel[IDX_W]) begin
                        idx_q       <= next_sel[IDX_W-1:0];
                        buf_raddr_q <= src_q + ADDR_W'(next_sel[IDX_W-1:0]);
                        state_q     <= S_LD_ADDR;
                    end else begin
                        exec_q  <= mask_q;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    pend_q <= pend_d;
                    // Completions arriving this cycle count towards leaving now
                    if (pend_d == mask_q) begin
                        idx_q       <= first_msk[IDX_W-1:0];
                        output_re_q <= f_onehot(first_msk[IDX_W-1:0]);
                        state_q     <= S_UL_RE;
                    end
                end
                S_UL_RE: begin
                    buf_we_q    <= 1'b1;
                    buf_waddr_q <= dst_q + ADDR_W'(idx_q);
                    state_q     <= S_UL_WR;
                end
                S_UL_WR: begin
                    if (next_sel[IDX_W]) begin
                        idx_q       <= next_sel[IDX_W-1:0];
                        output_re_q <= f_onehot(next_sel[IDX_W-1:0]);
                        state_q     <= S_UL_RE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    mask_q  <= '0;
                    src_q   <= '0;
                    dst_q   <= '0;
                    pend_q  <= '0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign buf_raddr_o  = buf_raddr_q;
    assign buf_we_o     = buf_we_q;
    assign buf_waddr_o  = buf_waddr_q;
    assign buf_wdata_o  = output_data_i;
    assign input_we_o   = input_we_q;
    assign input_data_o = buf_rdata_i;
    assign exec_o       = exec_q;
    assign output_re_o  = output_re_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stmm_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stmm_seq
// Description : Self-checking bench for stmm_seq with buffer and sub-unit
//               models and a scoreboard of expected loads, exec, writes, done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stmm_seq;

    localparam int SUB = 4;
    localparam int N   = 176;
    localparam int AW  = 8;
    localparam int DW  = N * 8;

    typedef struct packed {
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic [SUB-1:0] oh;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [SUB-1:0]  cmd_mask = '0;
    logic [AW-1:0]   cmd_src = '0;
    logic [AW-1:0]   cmd_dst = '0;
    logic [AW-1:0]   buf_raddr;
    logic [DW-1:0]   buf_rdata = '0;
    logic            buf_we;
    logic [AW-1:0]   buf_waddr;
    logic [DW-1:0]   buf_wdata;
    logic [SUB-1:0]  input_we;
    logic [DW-1:0]   input_data;
    logic [SUB-1:0]  exec;
    logic [SUB-1:0]  exec_done = '0;
    logic [SUB-1:0]  output_re;
    logic [DW-1:0]   output_data = '0;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0]   mem [256];
    logic [DW-1:0]   xreg [SUB];
    logic [DW-1:0]   y_tmp;
    int              dly [SUB];
    int              due [SUB] = '{-1, -1, -1, -1};
    logic [SUB-1:0]  spur = '0;
    logic [AW-1:0]   prev_raddr = '0;
    logic [SUB-1:0]  prev_ore = '0;
    logic            done_flag = 1'b0;
    int              done_cnt = 0;

    ent_t            ld_q [$];
    ent_t            wr_q [$];
    logic [SUB-1:0]  exec_q [$];
    int              done_q [$];

    stmm_seq #(.SUB_NUM(SUB), .N(N), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_mask_i     (cmd_mask),
        .cmd_src_addr_i (cmd_src),
        .cmd_dst_addr_i (cmd_dst),
        .buf_raddr_o    (buf_raddr),
        .buf_rdata_i    (buf_rdata),
        .buf_we_o       (buf_we),
        .buf_waddr_o    (buf_waddr),
        .buf_wdata_o    (buf_wdata),
        .input_we_o     (input_we),
        .input_data_o   (input_data),
        .exec_o         (exec),
        .exec_done_i    (exec_done),
        .output_re_o    (output_re),
        .output_data_i  (output_data),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fold(input logic [DW-1:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DW / 32; i++) r ^= v[i*32 +: 32];
        return r;
    endfunction

    // Sub-unit transform used both by the model and by the expectations
    function automatic logic [DW-1:0] f_y(input logic [DW-1:0] x, input int j);
        logic [7:0] k;
        k = 8'h5A + 8'(j * 13);
        return ~x ^ {N{k}};
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (low128; fold %h vs %h)",
                     tag, got[127:0], exp[127:0], fold(got), fold(exp));
        end
    endtask

    // Buffer memory (1-cycle read) and sub-unit X/Y registers
    always @(posedge clk) begin
        cyc++;
        if (buf_we) mem[buf_waddr] = buf_wdata;
        buf_rdata <= mem[buf_raddr];
        y_tmp = '0;
        for (int j = 0; j < SUB; j++) begin
            if (input_we[j]) xreg[j] <= input_data;
            if (output_re[j]) y_tmp = f_y(xreg[j], j);
        end
        output_data <= y_tmp;
    end

    // Output monitor and completion generator, evaluated mid-cycle
    always @(negedge clk) begin
        ent_t e;
        logic [SUB-1:0] ed;
        if (!rst_n) begin
            for (int j = 0; j < SUB; j++) due[j] = -1;
            ld_q.delete(); wr_q.delete(); exec_q.delete(); done_q.delete();
        end else begin
            if (input_we != '0) begin
                if (ld_q.size() == 0) check_val("extra_load", DW'(input_we), '0);
                else begin
                    e = ld_q.pop_front();
                    check_val("ld_we", DW'(input_we), DW'(e.oh));
                    check_val("ld_raddr", DW'(prev_raddr), DW'(e.a));
                    check_val("ld_data", input_data, e.d);
                end
            end
            if (exec != '0) begin
                if (exec_q.size() == 0) check_val("extra_exec", DW'(exec), '0);
                else check_val("exec", DW'(exec), DW'(exec_q.pop_front()));
                for (int j = 0; j < SUB; j++) if (exec[j]) due[j] = cyc + dly[j];
            end
            if (buf_we) begin
                if (wr_q.size() == 0) check_val("extra_write", DW'(buf_waddr), '1);
                else begin
                    e = wr_q.pop_front();
                    check_val("wr_re", DW'(prev_ore), DW'(e.oh));
                    check_val("wr_addr", DW'(buf_waddr), DW'(e.a));
                    check_val("wr_data", buf_wdata, e.d);
                end
            end
            if (done) begin
                done_cnt++;
                done_flag = 1'b1;
                if (done_q.size() == 0) check_val("extra_done", 1, 0);
                else check_val("done_cyc", DW'(cyc), DW'(done_q.pop_front()));
            end
        end
        ed = spur;
        for (int j = 0; j < SUB; j++) if (due[j] == cyc) ed[j] = 1'b1;
        exec_done  = ed;
        prev_raddr = buf_raddr;
        prev_ore   = output_re;
    end

    task automatic start_cmd(input logic [SUB-1:0] m, input logic [AW-1:0] s,
                             input logic [AW-1:0] d, input int hold);
        int k = 0;
        int dmax = 0;
        int n = 0;
        ent_t e;
        logic [AW-1:0] a;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check_val("ready_idle", DW'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_mask = m; cmd_src = s; cmd_dst = d;
        for (int j = 0; j < SUB; j++) begin
            if (m[j]) begin
                k++;
                if (dly[j] > dmax) dmax = dly[j];
                e.oh = '0; e.oh[j] = 1'b1;
                a = s + AW'(j);
                e.a = a; e.d = mem[a];
                ld_q.push_back(e);
                e.d = f_y(mem[a], j);
                e.a = d + AW'(j);
                wr_q.push_back(e);
            end
        end
        if (m != '0) exec_q.push_back(m);
        done_q.push_back((m == '0) ? cyc + 1 : cyc + 4 * k + dmax + 2);
        done_flag = 1'b0;
        @(negedge clk);
        check_val("busy_after_acc", DW'(busy), 1);
        for (int i = 0; i < hold; i++) begin
            cmd_mask = ~m; cmd_src = 8'h77; cmd_dst = 8'h78;
            check_val("ready_busy", DW'(cmd_ready), 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_flag && n < 300) begin @(negedge clk); n++; end
        if (!done_flag) check_val("done_timeout", 0, 1);
        @(negedge clk);
        check_val("idle_busy", DW'(busy), 0);
        check_val("wr_left", DW'(wr_q.size()), 0);
        check_val("ld_left", DW'(ld_q.size()), 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < N; b++) mem[a][b*8 +: 8] = 8'($urandom);
        for (int j = 0; j < SUB; j++) dly[j] = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", DW'(busy), 0);
        check_val("rst_done", DW'(done), 0);
        check_val("rst_strobes", DW'({input_we, exec, output_re, buf_we}), 0);
        check_val("rst_addr", DW'({buf_raddr, buf_waddr}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", DW'(cmd_ready), 1);

        // Single sub, completion 3 cycles after exec
        dly[0] = 3;
        start_cmd(4'b0001, 8'h10, 8'h20, 0); wait_done();

        // Two subs, sub3 completes before sub1
        dly[1] = 5; dly[3] = 2;
        start_cmd(4'b1010, 8'h40, 8'h50, 0); wait_done();

        // All subs with source address wrap
        dly[0] = 2; dly[1] = 1; dly[2] = 4; dly[3] = 3;
        start_cmd(4'b1111, 8'hFE, 8'h80, 0); wait_done();

        // Empty mask
        start_cmd(4'b0000, 8'h30, 8'h31, 0); wait_done();

        // Spurious completion on an unselected sub, command held while busy
        spur = 4'b0100; dly[0] = 2;
        start_cmd(4'b0001, 8'h60, 8'h61, 4); wait_done();
        spur = '0;

        // Reset while waiting for completions
        dly[0] = 20; dly[1] = 20;
        start_cmd(4'b0011, 8'h90, 8'hA0, 0);
        repeat (6) @(negedge clk);
        check_val("wait_busy", DW'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", DW'(busy), 0);
        check_val("mid_rst_done", DW'(done), 0);
        check_val("mid_rst_strobes", DW'({input_we, exec, output_re, buf_we}), 0);
        check_val("mid_rst_addr", DW'({buf_raddr, buf_waddr}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        check_val("post_rst_ready", DW'(cmd_ready), 1);
        repeat (30) @(negedge clk);
        check_val("no_done_after_rst", DW'(done_cnt), 0);

        // Fresh command after reset
        dly[1] = 1; dly[2] = 3;
        start_cmd(4'b0110, 8'hC0, 8'hD0, 0); wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stmm_seq.md
STMM_SEQ -- requirements
Module: stmm_seq

Interface
REQ-001 SHALL have parameters: SUB_NUM, default 4, number of StMM sub-units; N, default 176, vector elements (8 bit each); ADDR_W, default 8, activation-buffer address width.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-004 SHALL have ports: cmd_mask  in  SUB_NUM  sub-units to run; cmd_src_addr  in  ADDR_W  input vector base; cmd_dst_addr  in  ADDR_W  result vector base.
REQ-005 SHALL have ports: buf_raddr  out  ADDR_W  buffer read address; buf_rdata  in  N*8  read data, valid 1 cycle after buf_raddr.
REQ-006 SHALL have ports: buf_we  out  1  buffer write strobe; buf_waddr  out  ADDR_W  write address; buf_wdata  out  N*8  write data.
REQ-007 SHALL have ports: input_we  out  SUB_NUM  X load strobe per sub; input_data  out  N*8  X vector; exec  out  SUB_NUM  start pulse per sub; exec_done  in  SUB_NUM  completion pulse per sub.
REQ-008 SHALL have ports: output_re  out  SUB_NUM  Y read select; output_data  in  N*8  Y, registered by consumer, valid 1 cycle after output_re.
REQ-009 SHALL have ports: busy  out  1  command in progress; done  out  1  single-cycle completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, LD_ADDR, LD_DATA, EXEC, WAIT, UL_RE, UL_WR, FIN.
REQ-011 SHALL assert cmd_ready only in IDLE, and on acceptance SHALL latch mask, src and dst.
REQ-012 SHALL process selected subs in ascending index order, skipping unselected ones; sub i uses buffer addresses src+i and dst+i, modulo 2^ADDR_W (wrap, no error).
REQ-013 In LD_ADDR SHALL drive buf_raddr=src+i; in the following LD_DATA cycle SHALL assert input_we[i] only and drive input_data=buf_rdata.
REQ-014 After the last load SHALL spend exactly one EXEC cycle, pulsing exec[j]=1 for every selected j simultaneously.
REQ-015 In WAIT SHALL OR exec_done into sticky pending bits, masked by the latched mask; unselected exec_done bits SHALL be ignored.
REQ-016 SHALL leave WAIT on the cycle after the sticky bits equal the mask, including bits arriving in that same cycle.
REQ-017 In UL_RE SHALL assert output_re[i] only; in the next UL_WR cycle SHALL assert buf_we with buf_waddr=dst+i and buf_wdata=output_data.
REQ-018 After the last unload SHALL enter FIN, pulse done for one cycle, and return to IDLE.
REQ-019 With k selected subs and W WAIT cycles, done SHALL occur 4k+W+2 cycles after acceptance.
REQ-020 A zero mask SHALL go IDLE->FIN directly: no buffer, input, exec or output activity, and done exactly 1 cycle after acceptance.
REQ-021 busy SHALL be high in every state except IDLE.
REQ-022 input_we, exec, output_re and buf_we SHALL be one-hot or zero, except exec in EXEC; all are 0 outside their named states.
REQ-023 input_data and buf_wdata SHALL be combinational pass-throughs; all other outputs SHALL decode from registered state only.
REQ-024 cmd_valid while busy SHALL be ignored (cmd_ready=0) with no state corruption.

Reset
REQ-025 On rst_n low, at any time including mid-command, SHALL enter IDLE, clear latched command and sticky bits, and drive all strobes, busy, done and addresses to 0, with cmd_ready=1 after release.
REQ-026 A command interrupted by reset SHALL NOT resume, and no done SHALL be issued for it.

Verification
REQ-027 mask=4'b0001, src=8'h10, dst=8'h20, exec_done[0] 3 cycles after exec -> one load from 0x10, exec=0001, one write to 0x20 of Y, done at cycle 4+3+2=9.
REQ-028 mask=4'b1010, exec_done[3] before exec_done[1] -> loads sub1 then sub3, exec=1010 in one cycle, unload waits for both, writes dst+1 then dst+3.
REQ-029 mask=4'b1111, src=8'hFE -> read addresses FE, FF, 00, 01 (wrap), results in dst..dst+3.
REQ-030 mask=0 -> done 1 cycle after acceptance, no strobes asserted.
REQ-031 Spurious exec_done[2] with mask=4'b0001, and cmd_valid held while busy -> ignored, single command completes normally.
REQ-032 rst_n low during WAIT -> all outputs 0 immediately, no done; a new command after release completes correctly.
